spi_slave_echo_core: RTL
========================

SPI_SLAVE_ECHO_CORE -- requirements
Module: spi_slave_echo_core

Interface
REQ-001 Parameter WIDTH, default 8: bits per SPI word; SHALL be 4..32.
REQ-002 Parameter DEPTH, default 16: entries per RX and TX FIFO; SHALL be a power of 2, at least 2.
REQ-003 Parameter CPOL, default 0: SCLK idle level.
REQ-004 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 clk  in  1  single system clock; all logic SHALL be on posedge clk.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 cs_n, sclk, mosi  in  1 each  SPI inputs, already synchronised to clk.
REQ-008 miso  out  1  SPI serial output.
REQ-009 mode  in  2  00 host; 01 echo; 10 echo inverted (~word); 11 echo plus one (modulo 2^WIDTH).
REQ-010 rx_data  out  WIDTH, rx_valid  out  1, rx_ready  in  1  host RX pop port, first-word-fall-through.
REQ-011 tx_data  in  WIDTH, tx_valid  in  1, tx_ready  out  1  host TX push port.
REQ-012 rx_level, tx_level  out  $clog2(DEPTH)+1 each  FIFO occupancy.
REQ-013 rx_overflow, tx_underflow  out  1 each  sticky error flags.
REQ-014 clear_flags  in  1  clears both sticky flags.
REQ-015 frame_done  out  1  one-cycle pulse per completed word.

Function
REQ-016 sclk edge detection SHALL use a registered copy of sclk; edges are only recognised while cs_n=0.
REQ-017 Sample edge: rising when CPOL==CPHA, otherwise falling; the shift edge is the opposite edge.
REQ-018 Data SHALL be MSB first on both mosi and miso.
REQ-019 Frame start (cs_n 1->0 seen in clk): the TX shift register SHALL load the TX FIFO head and pop it.
REQ-020 If the TX FIFO is empty at a load, the engine SHALL load all zeros and set tx_underflow.
REQ-021 CPHA=0: miso SHALL present the MSB in the cycle after the cs_n fall.
REQ-022 CPHA=1: miso SHALL present the MSB after the first shift edge.
REQ-023 While cs_n=1, miso SHALL be 0.
REQ-024 On the WIDTH-th sample edge, the engine SHALL push the word to the RX FIFO and pulse frame_done in the next cycle.
REQ-025 On that same edge, the engine SHALL preload the next TX word per REQ-019/020, supporting back-to-back words without a cs_n toggle.
REQ-026 A push to a full RX FIFO SHALL drop the word and set rx_overflow; the FIFO contents SHALL be unchanged.
REQ-027 cs_n rising mid-word: the partial word SHALL be discarded, the bit counter cleared, no push made and no frame_done pulsed; the preloaded TX word is lost.
REQ-028 FIFO push is accepted iff level<DEPTH at the start of the cycle; pop is accepted iff level>0.
REQ-029 Simultaneous accepted push and pop SHALL leave the level unchanged; pointers wrap modulo DEPTH.
REQ-030 tx_ready = (tx_level<DEPTH) and mode==00; host pushes in echo modes SHALL be ignored.
REQ-031 rx_valid = (rx_level>0) and mode==00; a pop occurs on rx_valid and rx_ready.
REQ-032 Echo modes: in any cycle with RX non-empty and TX not full, the engine SHALL pop RX and push the transformed word to TX in that same cycle, giving 1 word/cycle throughput.
REQ-033 The echo transform SHALL be combinational on the RX head; the +1 transform SHALL wrap all-ones to zero.
REQ-034 A mode change takes effect next cycle; FIFO contents SHALL be preserved.
REQ-035 The sticky flags SHALL hold until clear_flags; a set and a clear_flags in the same cycle SHALL leave the flag set.

Reset
REQ-036 While rst=1, next clk: levels, pointers, bit counter, flags, frame_done, and miso SHALL be 0; rx_valid=0 and tx_ready=0.
REQ-037 Reset mid-frame SHALL abandon the frame with no RX push.
REQ-038 After rst falls with cs_n=0, the engine SHALL ignore sclk until cs_n has been seen high.

Verification
REQ-039 Mode 01, WIDTH=8, CPOL=0/CPHA=0: host sends 0xA5 then 0x3C in one cs_n window -> miso returns 0x00 (tx_underflow=1), then 0xA5.
REQ-040 Mode 11: send 0xFF and then 0x10 -> TX FIFO receives 0x00 and 0x11; mode 10 with 0x0F -> 0xF0.
REQ-041 Mode 00, DEPTH=4: send 5 words without popping -> rx_level=4, rx_overflow=1, and the first 4 words are read back in order.
REQ-042 Mode 00: push 0x81 via tx port; frame with CPHA=1, CPOL=1 -> miso bits 1,0,0,0,0,0,0,1 sampled on rising edges.
REQ-043 cs_n raised after 3 bits, then a full 0x5A frame -> one RX entry 0x5A and one frame_done pulse.
REQ-044 rst asserted after 4 bits with cs_n held low -> levels 0; the following sclk pulses are ignored until cs_n toggles high and low again.

Source files
------------

// File: rtl/spi_slave_echo_core.sv
// SPI slave with RX/TX FIFOs; in echo modes received words are transformed and
// queued back for transmission. SPI inputs are assumed already synchronised to clk.
module spi_slave_echo_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter bit          CPOL  = 1'b0,
  parameter bit          CPHA  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs_n,
  input  logic                   sclk,
  input  logic                   mosi,
  output logic                   miso,
  input  logic [1:0]             mode,
  output logic [WIDTH-1:0]       rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic                   rx_overflow,
  output logic                   tx_underflow,
  input  logic                   clear_flags,
  output logic                   frame_done
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam logic [LVL_W-1:0] FULL     = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic             sclk_q, cs_q, armed_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-2:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic             miso_bit_q, miso_bit_d;
  logic             load_pend_q, load_pend_d;
  logic             frame_done_q;
  logic             rx_ovf_q, tx_unf_q;

  logic [WIDTH-1:0]  rx_mem [DEPTH];
  logic [WIDTH-1:0]  tx_mem [DEPTH];
  logic [ADDR_W-1:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic [LVL_W-1:0]  rx_level_q, tx_level_q;

  logic             active, start, rise, fall, sample_edge, shift_edge, word_done;
  logic             load;
  logic [WIDTH-1:0] rx_word, load_word, tx_head, rx_head, echo_word, tx_push_data;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             echo, rx_push, rx_pop, tx_push, tx_pop;

  // Edges count only once cs_n has been seen high since reset.
  assign active      = ~cs_n & armed_q;
  assign start       = active & cs_q;
  assign rise        = sclk & ~sclk_q;
  assign fall        = ~sclk & sclk_q;
  assign sample_edge = active & ~start & ((CPOL == CPHA) ? rise : fall);
  assign shift_edge  = active & ~start & ((CPOL == CPHA) ? fall : rise);
  assign rx_word     = {rx_shift_q, mosi};
  assign word_done   = sample_edge & (bit_cnt_q == LAST_BIT);

  assign rx_full  = (rx_level_q == FULL);
  assign rx_empty = (rx_level_q == '0);
  assign tx_full  = (tx_level_q == FULL);
  assign tx_empty = (tx_level_q == '0);
  assign rx_head  = rx_mem[rx_rptr_q];
  assign tx_head  = tx_mem[tx_rptr_q];

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    miso_bit_d  = miso_bit_q;
    load_pend_d = load_pend_q;
    load        = 1'b0;
    load_word   = tx_empty ? '0 : tx_head;
    if (!active) begin
      bit_cnt_d   = '0;
      miso_bit_d  = 1'b0;
      load_pend_d = 1'b0;
    end else if (start) begin
      load       = 1'b1;
      tx_shift_d = load_word;
    end else if (sample_edge) begin
      rx_shift_d = rx_word[WIDTH-2:0];
      if (word_done) begin
        bit_cnt_d = '0;
        // An empty TX FIFO is re-checked at the shift edge so a word echoed
        // from the one just received can still go out back-to-back.
        if (tx_empty) begin
          load_pend_d = 1'b1;
        end else begin
          load       = 1'b1;
          tx_shift_d = load_word;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end else if (shift_edge) begin
      if (load_pend_q) begin
        load        = 1'b1;
        load_pend_d = 1'b0;
        if (CPHA) begin
          miso_bit_d = load_word[WIDTH-1];
          tx_shift_d = {load_word[WIDTH-2:0], 1'b0};
        end else begin
          tx_shift_d = load_word;
        end
      end else if (CPHA) begin
        miso_bit_d = tx_shift_q[WIDTH-1];
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end else if (bit_cnt_q != '0) begin
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    unique case (mode)
      2'b10:   echo_word = ~rx_head;
      2'b11:   echo_word = rx_head + WIDTH'(1);
      default: echo_word = rx_head;
    endcase
  end

  assign echo         = (mode != 2'b00) & ~rx_empty & ~tx_full;
  assign rx_valid     = ~rst & (mode == 2'b00) & ~rx_empty;
  assign tx_ready     = ~rst & (mode == 2'b00) & ~tx_full;
  assign rx_push      = word_done & ~rx_full;
  assign rx_pop       = (rx_valid & rx_ready) | echo;
  assign tx_push      = (tx_valid & tx_ready) | echo;
  assign tx_push_data = echo ? echo_word : tx_data;
  assign tx_pop       = load & ~tx_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q       <= CPOL;
      cs_q         <= 1'b0;
      armed_q      <= 1'b0;
      bit_cnt_q    <= '0;
      rx_shift_q   <= '0;
      tx_shift_q   <= '0;
      miso_bit_q   <= 1'b0;
      load_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      rx_ovf_q     <= 1'b0;
      tx_unf_q     <= 1'b0;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      rx_level_q   <= '0;
      tx_level_q   <= '0;
    end else begin
      sclk_q       <= sclk;
      cs_q         <= cs_n;
      armed_q      <= cs_n | armed_q;
      bit_cnt_q    <= bit_cnt_d;
      rx_shift_q   <= rx_shift_d;
      tx_shift_q   <= tx_shift_d;
      miso_bit_q   <= miso_bit_d;
      load_pend_q  <= load_pend_d;
      frame_done_q <= word_done;
      rx_ovf_q     <= (rx_ovf_q & ~clear_flags) | (word_done & rx_full);
      tx_unf_q     <= (tx_unf_q & ~clear_flags) | (load & tx_empty);
      if (rx_push) rx_wptr_q <= rx_wptr_q + ADDR_W'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + ADDR_W'(1);
      if (tx_push) tx_wptr_q <= tx_wptr_q + ADDR_W'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + ADDR_W'(1);
      rx_level_q <= rx_level_q + LVL_W'(rx_push) - LVL_W'(rx_pop);
      tx_level_q <= tx_level_q + LVL_W'(tx_push) - LVL_W'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_q] <= rx_word;
    if (tx_push) tx_mem[tx_wptr_q] <= tx_push_data;
  end

  assign miso         = active & ~start & (CPHA ? miso_bit_q : tx_shift_q[WIDTH-1]);
  assign rx_data      = rx_head;
  assign rx_level     = rx_level_q;
  assign tx_level     = tx_level_q;
  assign rx_overflow  = rx_ovf_q;
  assign tx_underflow = tx_unf_q;
  assign frame_done   = frame_done_q;

endmodule
